// File: rtl/proc_control_fsm.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, optional data-memory
// access and writeback, with sticky trap on decode exception or memory timeout.
module proc_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned RETIRE_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  output logic                imem_req,
  input  logic                imem_ready,
  output logic                ir_load,
  input  logic                dec_reg_write_enable,
  input  logic                dec_mem_write_enable,
  input  logic [1:0]          dec_dst_data_source,
  input  logic                dec_exception,
  output logic                dmem_req,
  output logic                dmem_we,
  input  logic                dmem_ready,
  output logic                rf_we,
  output logic                pc_we,
  output logic [2:0]          state,
  output logic                halted,
  output logic [1:0]          trap_cause,
  output logic [RETIRE_W-1:0] retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd7;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  localparam logic [1:0] SRC_MEMORY = 2'd0;

  // Last wait-count value before the access is abandoned (MEM_TIMEOUT is 1..255).
  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  logic [2:0]          state_q;
  logic [2:0]          state_d;
  logic [7:0]          to_cnt_q;
  logic [1:0]          cause_q;
  logic [RETIRE_W-1:0] retired_q;
  logic                mem_timeout;

  assign mem_timeout = (state_q == S_MEM) && !dmem_ready && (to_cnt_q == TO_LAST);

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  if (imem_ready) state_d = S_DECODE;
      S_DECODE: state_d = dec_exception ? S_TRAP : S_EXEC;
      S_EXEC:   state_d = ((dec_dst_data_source == SRC_MEMORY) || dec_mem_write_enable)
                          ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_ready)       state_d = S_WB;
        else if (mem_timeout) state_d = S_TRAP;
      end
      S_WB:     state_d = run ? S_FETCH : S_IDLE;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      to_cnt_q  <= 8'd0;
      cause_q   <= CAUSE_NONE;
      retired_q <= '0;
    end else begin
      state_q <= state_d;

      if ((state_q == S_MEM) && !dmem_ready && !mem_timeout) to_cnt_q <= to_cnt_q + 8'd1;
      else                                                    to_cnt_q <= 8'd0;

      if ((state_q == S_DECODE) && dec_exception) cause_q <= CAUSE_ILLEGAL;
      else if (mem_timeout)                       cause_q <= CAUSE_TIMEOUT;

      if (state_q == S_WB) retired_q <= retired_q + RETIRE_W'(1);
    end
  end

  // Moore outputs decoded from the state register; ir_load alone follows imem_ready.
  assign imem_req   = (state_q == S_FETCH);
  assign ir_load    = (state_q == S_FETCH) && imem_ready;
  assign dmem_req   = (state_q == S_MEM);
  assign dmem_we    = (state_q == S_MEM) && dec_mem_write_enable;
  assign rf_we      = (state_q == S_WB) && dec_reg_write_enable;
  assign pc_we      = (state_q == S_WB);
  assign halted     = (state_q == S_TRAP);
  assign state      = state_q;
  assign trap_cause = cause_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_proc_control_fsm.sv
// Table-driven bench for proc_control_fsm: per-cycle vectors of decoder/handshake
// inputs with hand-derived expected state, strobes, trap cause and retire count.
module tb_proc_control_fsm;

  typedef enum logic [1:0] {I_ALU, I_SW, I_LW, I_FENCE} ins_e;

  typedef struct {
    logic       rst;   // pulse reset before this vector
    logic       run;
    logic       imr;
    logic       dmr;
    ins_e       ins;
    logic [2:0] st;
    logic [6:0] strb;  // {imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_we, halted}
    logic [1:0] tc;
    logic [31:0] ret;
  } vec_t;

  typedef struct {
    logic [2:0]  st;
    logic [6:0]  strb;
    logic [1:0]  tc;
    logic [31:0] ret;
    int          idx;
  } exp_t;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                         ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5, ST_TRAP = 3'd7;

  localparam logic [6:0] SB_NONE   = 7'b0000000;
  localparam logic [6:0] SB_FETCH  = 7'b1100000;
  localparam logic [6:0] SB_FHOLD  = 7'b1000000;
  localparam logic [6:0] SB_MEM_RD = 7'b0010000;
  localparam logic [6:0] SB_MEM_WR = 7'b0011000;
  localparam logic [6:0] SB_WB_RF  = 7'b0000110;
  localparam logic [6:0] SB_WB_NRF = 7'b0000010;
  localparam logic [6:0] SB_TRAP   = 7'b0000001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        imem_req;
  logic        imem_ready = 1'b0;
  logic        ir_load;
  logic        dec_reg_write_enable = 1'b0;
  logic        dec_mem_write_enable = 1'b0;
  logic [1:0]  dec_dst_data_source = 2'd3;
  logic        dec_exception = 1'b0;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready = 1'b0;
  logic        rf_we;
  logic        pc_we;
  logic [2:0]  state;
  logic        halted;
  logic [1:0]  trap_cause;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  vec_t tbl[$];
  exp_t sb[$];
  logic [31:0] ret_exp;

  proc_control_fsm #(.MEM_TIMEOUT(16), .RETIRE_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_ready(imem_ready), .ir_load(ir_load),
    .dec_reg_write_enable(dec_reg_write_enable),
    .dec_mem_write_enable(dec_mem_write_enable),
    .dec_dst_data_source(dec_dst_data_source),
    .dec_exception(dec_exception),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .rf_we(rf_we), .pc_we(pc_we), .state(state), .halted(halted),
    .trap_cause(trap_cause), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Decoder outputs for the instruction words used in the test plan.
  task automatic drive_dec(input ins_e ins);
    case (ins)
      I_ALU:   begin dec_reg_write_enable = 1; dec_mem_write_enable = 0; dec_dst_data_source = 2'd2; dec_exception = 0; end // 0x00500093 addi
      I_SW:    begin dec_reg_write_enable = 0; dec_mem_write_enable = 1; dec_dst_data_source = 2'd3; dec_exception = 0; end // 0x0020A023 sw
      I_LW:    begin dec_reg_write_enable = 1; dec_mem_write_enable = 0; dec_dst_data_source = 2'd0; dec_exception = 0; end // 0x0000A103 lw
      default: begin dec_reg_write_enable = 0; dec_mem_write_enable = 0; dec_dst_data_source = 2'd3; dec_exception = 1; end // 0x0000000F fence
    endcase
  endtask

  task automatic add(input bit rst, input bit r, input bit imr, input bit dmr, input ins_e ins,
                     input logic [2:0] st, input logic [6:0] strb, input logic [1:0] tc);
    vec_t v;
    v.rst = rst; v.run = r; v.imr = imr; v.dmr = dmr; v.ins = ins;
    v.st = st; v.strb = strb; v.tc = tc; v.ret = ret_exp;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    run = 0; imem_ready = 0; dmem_ready = 0;
    drive_dec(I_ALU);
    #1;
    check("rst_state",    32'(state), 32'(ST_IDLE));
    check("rst_strobes",  32'({imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_we, halted}), 32'(SB_NONE));
    check("rst_cause",    32'(trap_cause), 32'd0);
    check("rst_retired",  retired, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    exp_t got;
    if (v.rst) do_reset();
    @(posedge clk);
    #1;
    run = v.run; imem_ready = v.imr; dmem_ready = v.dmr;
    drive_dec(v.ins);
    e.st = v.st; e.strb = v.strb; e.tc = v.tc; e.ret = v.ret; e.idx = idx;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    check($sformatf("v%0d_state", got.idx), 32'(state), 32'(got.st));
    check($sformatf("v%0d_strobes", got.idx),
          32'({imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_we, halted}), 32'(got.strb));
    check($sformatf("v%0d_cause", got.idx), 32'(trap_cause), 32'(got.tc));
    check($sformatf("v%0d_retired", got.idx), retired, got.ret);
  endtask

  initial begin
    // Three back-to-back ALU ops; a stray dmem_ready in DECODE is ignored.
    ret_exp = 0;
    add(1, 1, 1, 0, I_ALU, ST_IDLE, SB_NONE, 0);
    for (int i = 0; i < 3; i++) begin
      add(0, 1, 1, 0,        I_ALU, ST_FETCH,  SB_FETCH, 0);
      add(0, 1, 1, (i == 1), I_ALU, ST_DECODE, SB_NONE,  0);
      add(0, 1, 1, 0,        I_ALU, ST_EXEC,   SB_NONE,  0);
      add(0, 1, 1, 0,        I_ALU, ST_WB,     SB_WB_RF, 0);
      ret_exp++;
    end
    // Store with three wait cycles: 8 cycles total, no rf_we.
    add(0, 1, 1, 0, I_SW, ST_FETCH,  SB_FETCH, 0);
    add(0, 1, 1, 0, I_SW, ST_DECODE, SB_NONE,  0);
    add(0, 1, 1, 0, I_SW, ST_EXEC,   SB_NONE,  0);
    for (int i = 0; i < 3; i++) add(0, 1, 1, 0, I_SW, ST_MEM, SB_MEM_WR, 0);
    add(0, 1, 1, 1, I_SW, ST_MEM, SB_MEM_WR, 0);
    add(0, 1, 1, 0, I_SW, ST_WB,  SB_WB_NRF, 0);
    ret_exp++;
    // Load that never completes: trap after 16 MEM cycles, sticky.
    add(0, 1, 1, 0, I_LW, ST_FETCH,  SB_FETCH, 0);
    add(0, 1, 1, 0, I_LW, ST_DECODE, SB_NONE,  0);
    add(0, 1, 1, 0, I_LW, ST_EXEC,   SB_NONE,  0);
    for (int i = 0; i < 16; i++) add(0, 1, 1, 0, I_LW, ST_MEM, SB_MEM_RD, 0);
    add(0, 1, 1, 1, I_LW, ST_TRAP, SB_TRAP, 2);
    add(0, 0, 0, 1, I_LW, ST_TRAP, SB_TRAP, 2);
    add(0, 1, 1, 0, I_LW, ST_TRAP, SB_TRAP, 2);

    // Fetch held for wait states (run ignored mid-fetch), then illegal instruction.
    ret_exp = 0;
    add(1, 1, 0, 0, I_FENCE, ST_IDLE,   SB_NONE,  0);
    add(0, 1, 0, 0, I_FENCE, ST_FETCH,  SB_FHOLD, 0);
    add(0, 0, 0, 0, I_FENCE, ST_FETCH,  SB_FHOLD, 0);
    add(0, 0, 1, 0, I_FENCE, ST_FETCH,  SB_FETCH, 0);
    add(0, 0, 0, 0, I_FENCE, ST_DECODE, SB_NONE,  0);
    add(0, 1, 1, 1, I_FENCE, ST_TRAP,   SB_TRAP,  1);
    add(0, 1, 1, 1, I_ALU,   ST_TRAP,   SB_TRAP,  1);
    add(0, 0, 0, 0, I_LW,    ST_TRAP,   SB_TRAP,  1);

    // run dropped in EXEC: WB retires, park in IDLE, resume five cycles later.
    ret_exp = 0;
    add(1, 1, 1, 0, I_ALU, ST_IDLE,   SB_NONE,  0);
    add(0, 1, 1, 0, I_ALU, ST_FETCH,  SB_FETCH, 0);
    add(0, 1, 1, 0, I_ALU, ST_DECODE, SB_NONE,  0);
    add(0, 0, 1, 0, I_ALU, ST_EXEC,   SB_NONE,  0);
    add(0, 0, 1, 0, I_ALU, ST_WB,     SB_WB_RF, 0);
    ret_exp++;
    for (int i = 0; i < 5; i++) add(0, 0, 1, 1, I_ALU, ST_IDLE, SB_NONE, 0);
    add(0, 1, 1, 0, I_ALU, ST_IDLE,   SB_NONE,  0);
    add(0, 1, 1, 0, I_ALU, ST_FETCH,  SB_FETCH, 0);
    add(0, 1, 1, 0, I_ALU, ST_DECODE, SB_NONE,  0);
    add(0, 1, 1, 0, I_ALU, ST_EXEC,   SB_NONE,  0);
    add(0, 1, 1, 0, I_ALU, ST_WB,     SB_WB_RF, 0);
    ret_exp++;
    add(0, 1, 1, 0, I_LW, ST_FETCH,  SB_FETCH,  0);
    add(0, 1, 1, 0, I_LW, ST_DECODE, SB_NONE,   0);
    add(0, 1, 1, 0, I_LW, ST_EXEC,   SB_NONE,   0);
    add(0, 1, 1, 0, I_LW, ST_MEM,    SB_MEM_RD, 0);

    // Reset mid-MEM, then loads whose ready arrives on the final count cycle.
    ret_exp = 0;
    add(1, 1, 1, 0, I_LW, ST_IDLE, SB_NONE, 0);
    for (int n = 0; n < 2; n++) begin
      add(0, 1, 1, 0, I_LW, ST_FETCH,  SB_FETCH, 0);
      add(0, 1, 1, 0, I_LW, ST_DECODE, SB_NONE,  0);
      add(0, 1, 1, 0, I_LW, ST_EXEC,   SB_NONE,  0);
      for (int i = 0; i < 15; i++) add(0, 1, 1, 0, I_LW, ST_MEM, SB_MEM_RD, 0);
      add(0, 1, 1, 1, I_LW, ST_MEM, SB_MEM_RD, 0);
      add(0, 1, 1, 0, I_LW, ST_WB,  SB_WB_RF,  0);
      ret_exp++;
    end
    add(0, 1, 1, 0, I_ALU, ST_FETCH, SB_FETCH, 0);

    for (int k = 0; k < tbl.size(); k++) apply(tbl[k], k);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
